// File: rtl/probe_pkg.sv
// rtl/probe_pkg.sv - shared types and width helpers for the probe averaging reader
package probe_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int LOG2_N_MIN = 1;
    localparam int LOG2_N_MAX = 8;

    // Accumulator width: a full window of extreme samples fits without overflow.
    function automatic int acc_w(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

endpackage

// File: rtl/probe_result_reg.sv
// rtl/probe_result_reg.sv - single-entry valid/ready result holder with sticky overrun
module probe_result_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] dout,
    output logic         overrun
);

    logic can_load;

    // A new result may enter when the slot is empty or being drained this cycle.
    assign can_load = ~out_valid | out_ready;

    // Hold register: load, drain, or drop-and-flag when the consumer is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            overrun   <= 1'b0;
        end else begin
            if (load && can_load) begin
                out_valid <= 1'b1;
                dout      <= din;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (clear) begin
                overrun <= 1'b0;
            end else if (load && !can_load) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/probe_avg_reader.sv
// rtl/probe_avg_reader.sv - windowed mean of probe samples; PROBE_MINMAX_EN adds min/max
import probe_pkg::*;

module probe_avg_reader #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_mean,
`ifdef PROBE_MINMAX_EN
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
`endif
    output logic              overrun,
    output logic              busy
);

    localparam int ACC_W = acc_w(DATA_W, LOG2_N);
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);
`ifdef PROBE_MINMAX_EN
    localparam int RES_W = 3 * DATA_W;
`else
    localparam int RES_W = DATA_W;
`endif

    generate
        if (LOG2_N < LOG2_N_MIN || LOG2_N > LOG2_N_MAX) begin : g_bad_log2_n
            $error("probe_avg_reader: LOG2_N out of range");
        end
    endgenerate

    state_t                   state_q;
    state_t                   state_d;
    logic                     abort;
    logic                     accept;
    logic                     done;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]         cnt_q;
    logic [DATA_W-1:0]        mean;
    logic [RES_W-1:0]         res_din;
    logic [RES_W-1:0]         res_dout;

    assign accept     = in_valid & enable & ~clear;
    assign done       = accept & (cnt_q == CNT_LAST);
    assign sample_ext = {{LOG2_N{in_data[DATA_W-1]}}, in_data};
    assign sum        = acc_q + sample_ext;
    assign mean       = DATA_W'(sum >>> LOG2_N);
    assign busy       = (cnt_q != '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; leaving ACCUM throws away the partial window.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (!enable || clear) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accumulator and sample counter; wrap to zero on the window's last sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (abort) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (done) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            acc_q <= sum;
            cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef PROBE_MINMAX_EN
    logic signed [DATA_W-1:0] min_q;
    logic signed [DATA_W-1:0] max_q;
    logic signed [DATA_W-1:0] min_d;
    logic signed [DATA_W-1:0] max_d;

    // Running extremes including the current sample; the first sample seeds both.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (cnt_q == '0 || $signed(in_data) < min_q) begin
            min_d = $signed(in_data);
        end
        if (cnt_q == '0 || $signed(in_data) > max_q) begin
            max_d = $signed(in_data);
        end
    end

    // Extreme registers follow accepted samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '0;
            max_q <= '0;
        end else if (accept) begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign res_din = {min_d, max_d, mean};
    assign {out_min, out_max, out_mean} = res_dout;
`else
    assign res_din  = mean;
    assign out_mean = res_dout;
`endif

    probe_result_reg #(
        .W(RES_W)
    ) u_result (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .load      (done),
        .din       (res_din),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .dout      (res_dout),
        .overrun   (overrun)
    );

endmodule
